tape_progress: RTL and testbench



---
 rtl/tape_pkg.sv | 27 ++
 rtl/tape_progress_limiter.sv | 51 +++++
 rtl/tape_progress.sv | 144 ++++++++++++++
 tb/tb_tape_progress.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tape_pkg.sv
// ============================================================================
// Module   : tape_pkg
// Brief    : Shared types and defaults for the cassette transport tracker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tape_pkg;

    localparam int POS_W_DEF       = 24;
    localparam int UPD_GAP_DEF     = 32;
    localparam int HOLD_FRAMES_DEF = 120;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_EOT   = 2'd3
    } tape_state_t;

    function automatic logic is_running(input tape_state_t s);
        return (s == ST_PLAY);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tape_progress_limiter.sv
// ============================================================================
// Module   : progress_limiter
// Brief    : Throttles how often the internal byte count is republished as pos.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module progress_limiter
    import tape_pkg::*;
#(
    parameter int POS_W   = POS_W_DEF,
    parameter int UPD_GAP = UPD_GAP_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_clear,
    input  logic             i_force,
    input  logic [POS_W-1:0] i_cnt,
    output logic [POS_W-1:0] o_pos
);

    localparam int               c_GAP_W   = (UPD_GAP > 1) ? $clog2(UPD_GAP) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_MAX = c_GAP_W'(UPD_GAP - 1);

    logic [POS_W-1:0]   r_pos;
    logic [c_GAP_W-1:0] r_gap;
    logic               w_gap_sat;

    assign w_gap_sat = (r_gap == c_GAP_MAX);

    // Clear publishes zero at once and restarts the spacing window.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_pos <= '0;
            r_gap <= '0;
        end else if (i_clear) begin
            r_pos <= '0;
            r_gap <= '0;
        end else if (w_gap_sat && ((i_cnt != r_pos) || i_force)) begin
            r_pos <= i_cnt;
            r_gap <= '0;
        end else if (!w_gap_sat) begin
            r_gap <= r_gap + c_GAP_W'(1);
        end
    end

    assign o_pos = r_pos;

endmodule

`default_nettype wire

// File: rtl/tape_progress.sv
// ============================================================================
// Module   : tape_progress
// Brief    : Cassette transport FSM, byte counter and overlay enable hold.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tape_progress
    import tape_pkg::*;
#(
    parameter int UPD_GAP     = UPD_GAP_DEF,
    parameter int HOLD_FRAMES = HOLD_FRAMES_DEF,
    parameter int POS_W       = POS_W_DEF
) (
    input  logic             i_clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [POS_W-1:0] size,
    input  logic             play,
    input  logic             stop,
    input  logic             rewind,
    input  logic             byte_rd,
    input  logic             vsync,
    output logic [POS_W-1:0] pos,
    output logic [POS_W-1:0] max,
    output logic             ena,
    output logic             motor,
    output logic             eot
);

    localparam int                c_HOLD_W    = $clog2(HOLD_FRAMES + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_INIT = c_HOLD_W'(HOLD_FRAMES);

    tape_state_t         r_state;
    tape_state_t         w_state_nxt;
    logic [POS_W-1:0]    r_cnt;
    logic [POS_W-1:0]    w_cnt_nxt;
    logic [POS_W-1:0]    w_cnt_inc;
    logic [POS_W-1:0]    r_max;
    logic [c_HOLD_W-1:0] r_hold;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic                r_vsync_d;
    logic                w_vs_rise;
    logic                w_leave_play;
    logic                r_motor;
    logic                r_eot;
    logic                r_ena;

    assign w_cnt_inc = r_cnt + POS_W'(1);
    assign w_vs_rise = vsync & ~r_vsync_d;

    // Load outranks rewind, which outranks the play/stop requests; stop beats play.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (load || rewind) begin
            w_state_nxt = ST_STOP;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_STOP: begin
                    if (play && !stop && (r_max != '0)) begin
                        w_state_nxt = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (byte_rd && (r_cnt != r_max)) begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                    if (byte_rd && (w_cnt_inc == r_max)) begin
                        w_state_nxt = ST_EOT;
                    end else if (stop) begin
                        w_state_nxt = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (play && !stop) begin
                        w_state_nxt = ST_PLAY;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    assign w_leave_play = is_running(r_state) && !is_running(w_state_nxt);

    always_comb begin
        w_hold_nxt = r_hold;
        if (is_running(w_state_nxt)) begin
            w_hold_nxt = '0;
        end else if (w_leave_play) begin
            w_hold_nxt = c_HOLD_INIT;
        end else if (w_vs_rise && (r_hold != '0)) begin
            w_hold_nxt = r_hold - c_HOLD_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!reset_n) begin
            r_state   <= ST_STOP;
            r_cnt     <= '0;
            r_max     <= '0;
            r_hold    <= '0;
            r_vsync_d <= 1'b0;
            r_motor   <= 1'b0;
            r_eot     <= 1'b0;
            r_ena     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hold    <= w_hold_nxt;
            r_vsync_d <= vsync;
            r_motor   <= is_running(r_state);
            r_eot     <= (r_state == ST_EOT);
            r_ena     <= is_running(w_state_nxt) || (w_hold_nxt != '0);
            if (load) begin
                r_max <= size;
            end
        end
    end

    progress_limiter #(
        .POS_W   (POS_W),
        .UPD_GAP (UPD_GAP)
    ) u_limiter (
        .i_clk     (i_clk),
        .i_reset_n (reset_n),
        .i_clear   (load | rewind),
        .i_force   (r_state == ST_EOT),
        .i_cnt     (r_cnt),
        .o_pos     (pos)
    );

    assign max   = r_max;
    assign ena   = r_ena;
    assign motor = r_motor;
    assign eot   = r_eot;

endmodule

`default_nettype wire

// File: tb/tb_tape_progress.sv
// ============================================================================
// Module   : tb_tape_progress
// Brief    : Directed self-checking bench for tape_progress.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tape_progress;

    localparam int c_POS_W = 24;

    logic               i_clk = 1'b0;
    logic               reset_n;
    logic               load;
    logic [c_POS_W-1:0] size;
    logic               play;
    logic               stop;
    logic               rewind;
    logic               byte_rd;
    logic               vsync;
    logic [c_POS_W-1:0] pos;
    logic [c_POS_W-1:0] max;
    logic               ena;
    logic               motor;
    logic               eot;

    int n_cmp = 0;
    int n_bad = 0;

    tape_progress #(
        .UPD_GAP     (32),
        .HOLD_FRAMES (120),
        .POS_W       (c_POS_W)
    ) dut (
        .i_clk   (i_clk),
        .reset_n (reset_n),
        .load    (load),
        .size    (size),
        .play    (play),
        .stop    (stop),
        .rewind  (rewind),
        .byte_rd (byte_rd),
        .vsync   (vsync),
        .pos     (pos),
        .max     (max),
        .ena     (ena),
        .motor   (motor),
        .eot     (eot)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic vs_pulse();
        vsync = 1'b1;
        tick();
        tick();
        vsync = 1'b0;
        tick();
        tick();
    endtask

    initial begin : stim
        int last_chg;
        int min_gap;
        int seen10;
        logic [c_POS_W-1:0] prev_pos;

        reset_n = 1'b0; load = 1'b0; size = '0; play = 1'b0; stop = 1'b0;
        rewind = 1'b0; byte_rd = 1'b0; vsync = 1'b0;
        tick();
        tick();
        chk("rst_pos", 32'(pos), 0);
        chk("rst_max", 32'(max), 0);
        chk("rst_ena", 32'(ena), 0);
        chk("rst_motor", 32'(motor), 0);
        chk("rst_eot", 32'(eot), 0);
        reset_n = 1'b1;

        // play with no tape loaded is ignored
        play = 1'b1; tick(); play = 1'b0;
        tick();
        chk("nomax_motor", 32'(motor), 0);
        chk("nomax_ena", 32'(ena), 0);

        load = 1'b1; size = 24'd100; tick(); load = 1'b0;
        chk("load_max", 32'(max), 100);
        play = 1'b1; tick(); play = 1'b0;
        tick();
        chk("play_motor", 32'(motor), 1);
        chk("play_ena", 32'(ena), 1);

        // ten bytes, then watch publish spacing and latency
        prev_pos = pos; last_chg = -1000; min_gap = 1000; seen10 = -1;
        for (int i = 0; i < 50; i++) begin
            byte_rd = (i < 10);
            tick();
            if (pos != prev_pos) begin
                if (i - last_chg < min_gap) min_gap = i - last_chg;
                last_chg = i;
                prev_pos = pos;
            end
            if (pos == 24'd10 && seen10 < 0) seen10 = i;
        end
        byte_rd = 1'b0;
        chk("pos_spacing_ok", 32'(min_gap >= 32), 1);
        chk("pos10_latency_ok", 32'(seen10 >= 0 && (seen10 - 9) <= 32), 1);
        chk("pos_final10", 32'(pos), 10);

        // advance to cnt=50, then rewind
        byte_rd = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        byte_rd = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        chk("pos50", 32'(pos), 50);
        rewind = 1'b1; tick(); rewind = 1'b0;
        chk("rew_pos", 32'(pos), 0);
        chk("rew_ena", 32'(ena), 1);
        tick();
        chk("rew_motor", 32'(motor), 0);
        for (int i = 0; i < 40; i++) tick();
        chk("rew_pos_hold", 32'(pos), 0);

        // short tape: saturate at max, enter EOT
        load = 1'b1; size = 24'd3; tick(); load = 1'b0;
        chk("eot_max", 32'(max), 3);
        play = 1'b1; tick(); play = 1'b0;
        for (int i = 0; i < 5; i++) begin
            byte_rd = 1'b1;
            tick();
            if (i == 3) chk("eot_after3", 32'(eot), 1);
        end
        byte_rd = 1'b0;
        play = 1'b1; tick(); play = 1'b0;
        tick();
        chk("eot_play_ign", 32'(eot), 1);
        chk("eot_motor", 32'(motor), 0);
        for (int i = 0; i < 40; i++) tick();
        chk("eot_pos", 32'(pos), 3);

        // overlay hold after stop
        load = 1'b1; size = 24'd100; tick(); load = 1'b0;
        play = 1'b1; tick(); play = 1'b0;
        tick();
        stop = 1'b1; tick(); stop = 1'b0;
        for (int i = 0; i < 119; i++) vs_pulse();
        chk("hold_119", 32'(ena), 1);
        vs_pulse();
        chk("hold_120", 32'(ena), 0);

        play = 1'b1; tick(); play = 1'b0;
        tick();
        stop = 1'b1; tick(); stop = 1'b0;
        for (int i = 0; i < 60; i++) vs_pulse();
        play = 1'b1; tick(); play = 1'b0;
        for (int i = 0; i < 70; i++) vs_pulse();
        chk("cancel_ena", 32'(ena), 1);
        chk("cancel_motor", 32'(motor), 1);
        stop = 1'b1; tick(); stop = 1'b0;
        for (int i = 0; i < 120; i++) vs_pulse();
        chk("rehold_done", 32'(ena), 0);

        // load and rewind together
        load = 1'b1; rewind = 1'b1; size = 24'd200; tick();
        load = 1'b0; rewind = 1'b0;
        chk("lr_max", 32'(max), 200);
        chk("lr_pos", 32'(pos), 0);
        tick();
        chk("lr_motor", 32'(motor), 0);
        play = 1'b1; tick(); play = 1'b0;
        tick();
        chk("lr_play", 32'(motor), 1);
        play = 1'b1; stop = 1'b1; tick(); play = 1'b0; stop = 1'b0;
        tick();
        chk("ps_pause", 32'(motor), 0);
        chk("ps_eot", 32'(eot), 0);

        // reset mid-PLAY
        play = 1'b1; tick(); play = 1'b0;
        tick();
        chk("rp_motor", 32'(motor), 1);
        byte_rd = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        byte_rd = 1'b0;
        reset_n = 1'b0; tick();
        chk("mid_rst_pos", 32'(pos), 0);
        chk("mid_rst_max", 32'(max), 0);
        chk("mid_rst_ena", 32'(ena), 0);
        chk("mid_rst_motor", 32'(motor), 0);
        chk("mid_rst_eot", 32'(eot), 0);
        reset_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
